imm_operand_encoder: RTL and testbench
======================================

Name: imm_operand_encoder

Overview:
Encodes a 32-bit constant into the data-processing immediate shifter-operand form {rotate_imm[3:0], imm8[7:0]}, where the constant equals imm8 rotated right by 2*rotate_imm. The datapath shift/sign-extend stage performs the decode. This block performs the encode, serving the instruction-build and self-test logic.
- The search is iterative, one rotation per cycle, behind a start/done handshake.
- When ALLOW_INVERT is set, the block retries with the bitwise complement of the constant to support the MOV-to-MVN substitution.

Parameters:
ALLOW_INVERT, 1, 1 = run a second 16-rotation pass on ~value if the direct pass fails; 0 = direct pass only

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  synchronous, active-low reset
start  input  1  request; sampled only while busy=0
value  input  32  constant to encode; captured on an accepted start
busy  output  1  high while a search is in progress
done  output  1  one-cycle pulse when the result registers update
valid  output  1  1 = encoding found
inverted  output  1  1 = encoding is for ~value
rotate_imm  output  4  rotation field
imm8  output  8  8-bit immediate field
encoding  output  12  {rotate_imm, imm8}
carry_out  output  1  shifter carry implied by the encoding

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs (busy, done, valid, inverted, rotate_imm, imm8, encoding, carry_out) are 0 the next cycle.
  - Reset wins over every other event, including reset during a search; no done is produced for the aborted request.
- States and transitions:
  - IDLE: busy=0. On start=1, latch value into the working register, set rot=0 and pass=direct, and go to SEARCH.
  - SEARCH: busy=1. Each cycle, form cand = work rotated LEFT by 2*rot (32-bit rotate, wrap-around).
    - Hit when cand[31:8]==0. On a hit, go to DONE with rotate_imm=rot, imm8=cand[7:0], valid=1, and inverted set to the current pass.
    - Miss with rot<15: rot increments.
    - Miss with rot==15, pass=direct and ALLOW_INVERT=1: set work=~value latch, rot=0, pass=invert, and stay in SEARCH.
    - Otherwise (rot==15 miss on the final pass): go to DONE with valid=0 and rotate_imm, imm8, inverted and carry_out all 0.
  - DONE: done=1 and busy=0 for exactly one cycle. Result registers are updated on entry, then the state returns to IDLE. A start sampled in the DONE cycle is accepted, as in IDLE.
- Rotation order is 0 to 15, so the smallest rotate_imm always wins.
- Value 0 hits at rot=0 (imm8=0).
- Result fields hold their values from one done pulse until the next done pulse or reset. They do not change during busy.
- encoding always equals {rotate_imm, imm8}.
- carry_out:
  - 0 when rotate_imm==0 (the shifter leaves carry unchanged in that case).
  - Otherwise bit 31 of the encoded operand: value[31] on the direct pass, ~value[31] on the inverted pass.
- start while busy=1 is ignored, and value is not re-sampled.
- Latency, with start accepted at edge T:
  - Hit at rotation k on the direct pass: done is high in cycle T+2+k.
  - Inverted-pass hit at rotation k: done in cycle T+18+k.
  - Failure: done in cycle T+17 (ALLOW_INVERT=0) or T+33 (ALLOW_INVERT=1).
- The rotate amount is 2*rot, in the range 0..30, computed in 5 bits; no overflow is possible.

Test Plan:
- value=0x000000FF, start at T -> done at T+2; valid=1, rotate_imm=0, imm8=0xFF, encoding=0x0FF, carry_out=0, inverted=0.
- value=0xFF000000 -> done at T+6; rotate_imm=4, imm8=0xFF, encoding=0x4FF, carry_out=1. value=0xF000000F -> done at T+4; rotate_imm=2, imm8=0xFF, carry_out=1.
- value=0x000003FC -> done at T+17; rotate_imm=15, imm8=0xFF, carry_out=0, busy high for cycles T+1..T+16.
- ALLOW_INVERT=1: value=0xFFFFFF00 -> done at T+18; inverted=1, rotate_imm=0, imm8=0xFF. value=0x00000101 -> done at T+33; valid=0, encoding=0. Repeat with ALLOW_INVERT=0: both give done at T+17 with valid=0.
- Pulse start again at T+3 with value=0x1 while the first search (0xFF000000) runs -> ignored, first result unchanged. Then start in the DONE cycle with 0x1 -> accepted, done two cycles later with imm8=0x01.
- Drive reset_n=0 for one cycle at T+5 during a search of 0x000003FC -> next cycle busy=0 and all outputs 0. No done pulse for that request within the following 40 cycles.

Source files
------------

// File: rtl/imm_operand_encoder_if.sv
// Handshake and result bundle for the rotated-immediate encoder.
// The master side issues start/value; the slave side is the encoder.
interface imm_operand_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic        inverted;
  logic [3:0]  rotate_imm;
  logic [7:0]  imm8;
  logic [11:0] encoding;
  logic        carry_out;

  modport master (
    output start, value,
    input  busy, done, valid, inverted, rotate_imm, imm8, encoding, carry_out
  );

  modport slave (
    input  start, value,
    output busy, done, valid, inverted, rotate_imm, imm8, encoding, carry_out
  );
endinterface

// File: rtl/imm_operand_encoder.sv
// Iterative encoder of a 32-bit constant into {rotate_imm, imm8}.
// One rotation is tried per cycle; optional second pass on the complement for MOV/MVN.
module imm_operand_encoder #(
  parameter bit ALLOW_INVERT = 1'b1
) (
  input logic                 clk,
  input logic                 reset_n,
  imm_operand_encoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [3:0]  rot_q, rot_d;
  logic        pass_q, pass_d;

  logic        valid_q, valid_d;
  logic        inverted_q, inverted_d;
  logic [3:0]  rotate_q, rotate_d;
  logic [7:0]  imm8_q, imm8_d;
  logic        carry_q, carry_d;
  logic        load_res;

  // Rotate left by 2*rot: the upper half of the doubled word shifted left.
  logic [4:0]  shamt;
  logic [63:0] doubled;
  logic [31:0] cand;
  logic        hit;

  assign shamt   = {rot_q, 1'b0};
  assign doubled = {work_q, work_q} << shamt;
  assign cand    = doubled[63:32];
  assign hit     = (cand[31:8] == 24'd0);

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rot_d      = rot_q;
    pass_d     = pass_q;
    load_res   = 1'b0;
    valid_d    = 1'b0;
    inverted_d = 1'b0;
    rotate_d   = 4'd0;
    imm8_d     = 8'd0;
    carry_d    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          work_d  = bus.value;
          rot_d   = 4'd0;
          pass_d  = 1'b0;
          state_d = StSearch;
        end else begin
          state_d = StIdle;
        end
      end
      StSearch: begin
        if (hit) begin
          state_d    = StDone;
          load_res   = 1'b1;
          valid_d    = 1'b1;
          inverted_d = pass_q;
          rotate_d   = rot_q;
          imm8_d     = cand[7:0];
          // A zero rotation leaves the shifter carry untouched.
          carry_d    = (rot_q != 4'd0) && work_q[31];
        end else if (rot_q != 4'd15) begin
          rot_d = rot_q + 4'd1;
        end else if (!pass_q && ALLOW_INVERT) begin
          work_d = ~work_q;
          rot_d  = 4'd0;
          pass_d = 1'b1;
        end else begin
          state_d  = StDone;
          load_res = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      work_q     <= 32'd0;
      rot_q      <= 4'd0;
      pass_q     <= 1'b0;
      valid_q    <= 1'b0;
      inverted_q <= 1'b0;
      rotate_q   <= 4'd0;
      imm8_q     <= 8'd0;
      carry_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rot_q   <= rot_d;
      pass_q  <= pass_d;
      if (load_res) begin
        valid_q    <= valid_d;
        inverted_q <= inverted_d;
        rotate_q   <= rotate_d;
        imm8_q     <= imm8_d;
        carry_q    <= carry_d;
      end
    end
  end

  assign bus.busy       = (state_q == StSearch);
  assign bus.done       = (state_q == StDone);
  assign bus.valid      = valid_q;
  assign bus.inverted   = inverted_q;
  assign bus.rotate_imm = rotate_q;
  assign bus.imm8       = imm8_q;
  assign bus.encoding   = {rotate_q, imm8_q};
  assign bus.carry_out  = carry_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Bench for imm_operand_encoder: one instance per ALLOW_INVERT setting, driven in lockstep
// and checked against a search-by-arithmetic reference model.
module tb_imm_operand_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] value;

  always #5 clk = ~clk;

  imm_operand_encoder_if bus0();
  imm_operand_encoder_if bus1();

  assign bus0.start = start;
  assign bus0.value = value;
  assign bus1.start = start;
  assign bus1.value = value;

  imm_operand_encoder #(.ALLOW_INVERT(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  imm_operand_encoder #(.ALLOW_INVERT(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  // {valid, inverted, rotate_imm, imm8, encoding, carry_out}
  logic [26:0] res[2];
  logic        done_w[2];
  logic        busy_w[2];

  assign res[0] = {bus0.valid, bus0.inverted, bus0.rotate_imm, bus0.imm8, bus0.encoding,
                   bus0.carry_out};
  assign res[1] = {bus1.valid, bus1.inverted, bus1.rotate_imm, bus1.imm8, bus1.encoding,
                   bus1.carry_out};
  assign done_w[0] = bus0.done;
  assign done_w[1] = bus1.done;
  assign busy_w[0] = bus0.busy;
  assign busy_w[1] = bus1.busy;

  int compared   = 0;
  int mismatched = 0;

  int          lat[2];
  int          bcnt[2];
  logic [26:0] got[2];
  bit          stable[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Try every rotation of value, then of ~value, in order; first zero-upper-24 result wins.
  function automatic void model(input logic [31:0] v, input bit inv_ok,
                                output logic [26:0] r, output int l);
    logic [63:0] d;
    logic [31:0] w;
    logic [31:0] c;
    r = '0;
    l = inv_ok ? 33 : 17;
    for (int p = 0; p < 2; p++) begin
      if (p == 1 && !inv_ok) break;
      w = (p == 1) ? ~v : v;
      for (int k = 0; k < 16; k++) begin
        d = {w, w} << (2 * k);
        c = d[63:32];
        if (c[31:8] == 24'd0) begin
          r = {1'b1, (p == 1), 4'(k), c[7:0], 4'(k), c[7:0], ((k != 0) && w[31])};
          l = 2 + 16 * p + k;
          return;
        end
      end
    end
  endfunction

  // Called in cycle T+off after the accepting edge T; returns while in the last done cycle.
  task automatic collect(input int off);
    bit          seen[2];
    logic [26:0] snap[2];
    int          n;
    n = off;
    for (int d = 0; d < 2; d++) begin
      seen[d]   = 1'b0;
      lat[d]    = -1;
      bcnt[d]   = off - 1;
      stable[d] = 1'b1;
      snap[d]   = res[d];
      got[d]    = '0;
    end
    while (1) begin
      for (int d = 0; d < 2; d++) begin
        if (!seen[d]) begin
          if (done_w[d] === 1'b1) begin
            seen[d] = 1'b1;
            lat[d]  = n;
            got[d]  = res[d];
          end else begin
            if (busy_w[d] === 1'b1) bcnt[d]++;
            if (res[d] !== snap[d]) stable[d] = 1'b0;
          end
        end
      end
      if (seen[0] && seen[1]) break;
      if (n >= off + 45) break;
      tick();
      n++;
    end
  endtask

  task automatic verify(input string tag, input logic [31:0] v);
    logic [26:0] er;
    int          el;
    for (int d = 0; d < 2; d++) begin
      model(v, (d == 1), er, el);
      chk($sformatf("%s/ai%0d/latency v=%h", tag, d, v), lat[d], el);
      chk($sformatf("%s/ai%0d/result v=%h", tag, d, v), {5'd0, got[d]}, {5'd0, er});
      chk($sformatf("%s/ai%0d/busy_cycles", tag, d), bcnt[d], el - 1);
      chk($sformatf("%s/ai%0d/fields_held", tag, d), {31'd0, stable[d]}, 32'd1);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] v);
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    collect(1);
    verify(tag, v);
  endtask

  logic [31:0] directed[8] = '{32'h0000_00FF, 32'hFF00_0000, 32'hF000_000F, 32'h0000_03FC,
                               32'hFFFF_FF00, 32'h0000_0101, 32'h0000_0000, 32'hFFFF_FFFF};

  initial begin
    logic [63:0] dd;
    logic [31:0] x;
    int          ndone;

    reset_n = 1'b0;
    start   = 1'b0;
    value   = '0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset/ai%0d/result", d), {5'd0, res[d]}, 32'd0);
      chk($sformatf("reset/ai%0d/busy_done", d), {30'd0, busy_w[d], done_w[d]}, 32'd0);
    end
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run("directed", directed[i]);

    // Start pulsed mid-search is ignored; start in the done cycle is accepted.
    start = 1'b1;
    value = 32'hFF00_0000;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    value = 32'h0000_0001;
    tick();
    start = 1'b0;
    value = '0;
    collect(3);
    verify("ignored_start", 32'hFF00_0000);
    start = 1'b1;
    value = 32'h0000_0001;
    tick();
    start = 1'b0;
    collect(1);
    verify("done_cycle_start", 32'h0000_0001);

    for (int i = 0; i < 24; i++) begin
      x  = 32'($urandom_range(0, 255));
      dd = {x, x} >> (2 * $urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: x = dd[31:0];
        1: x = ~dd[31:0];
        2: x = $urandom;
        default: begin
          dd = {x | 32'h81, x | 32'h81} >> (2 * $urandom_range(0, 15) + 1);
          x  = dd[31:0];
        end
      endcase
      run("random", x);
    end

    // Reset mid-search aborts the request with no done pulse.
    start = 1'b1;
    value = 32'h0000_03FC;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midreset/ai%0d/result", d), {5'd0, res[d]}, 32'd0);
      chk($sformatf("midreset/ai%0d/busy_done", d), {30'd0, busy_w[d], done_w[d]}, 32'd0);
    end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_w[0] === 1'b1 || done_w[1] === 1'b1) ndone++;
      tick();
    end
    chk("midreset/no_done", ndone, 0);

    run("after_reset", 32'h0000_00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
